fp_addsub_pipe: RTL and testbench

Parametrised, pipelined IEEE-754 binary floating-point adder/subtractor. It is the successor to the single-precision combinational adder and adds the following:
- configurable exponent and mantissa widths;
- an add/sub mode bit;
- full special-value handling and gradual underflow;
- a 3-stage registered pipeline with valid/ready flow control.

It sits between the operand issue logic and the result writeback in the FPU datapath.

---
 rtl/fp_addsub_pipe.sv | 234 +++++++++++++++++++++++
 tb/tb_fp_addsub_pipe.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_addsub_pipe.sv
`default_nettype none
// ============================================================================
// Module   : fp_addsub_pipe
// Purpose  : Parametrised IEEE-754 binary floating-point adder/subtractor.
//            Three registered stages (align, add/normalise, round/pack)
//            with valid/ready flow control. Rounding is round-to-nearest-even
//            and subnormals are handled gradually.
// Ports    : clk, rst (async, active-high)
//            in_valid/in_ready, a, b, sub   - operand side (sub=1: a-b)
//            out_valid/out_ready, res       - result side
//            flag_invalid, flag_overflow, flag_inexact - result exceptions
// Revision : 1.0 - initial release
// ============================================================================
module fp_addsub_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] a,
    input  logic [EXP_W+MAN_W:0] b,
    input  logic                 sub,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] res,
    output logic                 flag_invalid,
    output logic                 flag_overflow,
    output logic                 flag_inexact
);
    localparam int c_W      = 1 + EXP_W + MAN_W;
    localparam int c_FW     = MAN_W + 4;            // hidden, frac, guard, round, sticky
    localparam int c_SH_MAX = MAN_W + 3;
    localparam int c_LZ_W   = $clog2(c_FW + 1);
    localparam int c_CW     = ((c_LZ_W > EXP_W) ? c_LZ_W : EXP_W) + 1;
    localparam logic [EXP_W-1:0] c_EXP_ONES = '1;
    localparam logic [c_W-1:0]   c_QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    function automatic logic [c_LZ_W-1:0] f_lzc(input logic [c_FW-1:0] v);
        f_lzc = c_LZ_W'(c_FW);
        // Ascending scan: the highest set bit is the last one to write.
        for (int i = 0; i < c_FW; i++) begin
            if (v[i]) f_lzc = c_LZ_W'(c_FW - 1 - i);
        end
    endfunction

    // Whole pipe shifts as one; only a full, unaccepted output stalls it.
    logic r3_valid;
    logic w_advance;
    assign w_advance = !r3_valid || out_ready;
    assign in_ready  = w_advance && !rst;

    // ---------------- S1: classify, swap, align ----------------
    logic             w_sa, w_sb;
    logic [EXP_W-1:0] w_ea, w_eb;
    logic [MAN_W-1:0] w_fa, w_fb;
    assign w_sa = a[c_W-1];
    assign w_ea = a[c_W-2:MAN_W];
    assign w_fa = a[MAN_W-1:0];
    assign w_sb = b[c_W-1] ^ sub;
    assign w_eb = b[c_W-2:MAN_W];
    assign w_fb = b[MAN_W-1:0];

    logic w_a_nan, w_b_nan, w_a_snan, w_b_snan, w_a_inf, w_b_inf, w_inf_clash;
    assign w_a_nan     = (w_ea == c_EXP_ONES) && (w_fa != '0);
    assign w_b_nan     = (w_eb == c_EXP_ONES) && (w_fb != '0);
    assign w_a_snan    = w_a_nan && !w_fa[MAN_W-1];
    assign w_b_snan    = w_b_nan && !w_fb[MAN_W-1];
    assign w_a_inf     = (w_ea == c_EXP_ONES) && (w_fa == '0);
    assign w_b_inf     = (w_eb == c_EXP_ONES) && (w_fb == '0);
    assign w_inf_clash = w_a_inf && w_b_inf && (w_sa != w_sb);

    logic             w_special, w_invalid;
    logic [c_W-1:0]   w_special_res;
    always_comb begin
        w_special = w_a_nan | w_b_nan | w_a_inf | w_b_inf;
        w_invalid = w_a_snan | w_b_snan | w_inf_clash;
        if (w_a_nan || w_b_nan || w_inf_clash) w_special_res = c_QNAN;
        else if (w_a_inf)                      w_special_res = {w_sa, a[c_W-2:0]};
        else                                   w_special_res = {w_sb, b[c_W-2:0]};
    end

    // A wins ties so that x-x keeps A's sign before the +0 override.
    logic             w_a_ge, w_sl, w_hl, w_hs;
    logic [EXP_W-1:0] w_el, w_es, w_el_eff, w_es_eff;
    logic [MAN_W-1:0] w_fl, w_fs;
    always_comb begin
        w_a_ge = {w_ea, w_fa} >= {w_eb, w_fb};
        w_sl   = w_a_ge ? w_sa : w_sb;
        w_el   = w_a_ge ? w_ea : w_eb;
        w_fl   = w_a_ge ? w_fa : w_fb;
        w_es   = w_a_ge ? w_eb : w_ea;
        w_fs   = w_a_ge ? w_fb : w_fa;
        w_hl   = (w_el != '0);
        w_hs   = (w_es != '0);
        w_el_eff = w_hl ? w_el : EXP_W'(1);
        w_es_eff = w_hs ? w_es : EXP_W'(1);
    end

    logic [c_CW-1:0]   w_diff_ext, w_shift;
    logic [2*c_FW-1:0] w_s_ext;
    logic [c_FW-1:0]   w_s_aligned;
    assign w_diff_ext = c_CW'(w_el_eff - w_es_eff);
    assign w_shift    = (w_diff_ext > c_CW'(c_SH_MAX)) ? c_CW'(c_SH_MAX) : w_diff_ext;
    // Lower half catches every bit pushed past the sticky position.
    assign w_s_ext     = {w_hs, w_fs, 3'b000, {c_FW{1'b0}}} >> w_shift;
    assign w_s_aligned = {w_s_ext[2*c_FW-1:c_FW+1], w_s_ext[c_FW] | (|w_s_ext[c_FW-1:0])};

    logic             r1_valid, r1_sign, r1_eff_sub, r1_special, r1_invalid;
    logic [EXP_W-1:0] r1_exp;
    logic [c_FW-1:0]  r1_ml, r1_ms;
    logic [c_W-1:0]   r1_special_res;

    // ---------------- S2: add / normalise ----------------
    logic [c_FW:0]     w_sum;
    logic [c_LZ_W-1:0] w_lzc;
    logic [c_CW-1:0]   w_lzc_ext, w_em1, w_lshift;
    logic [c_FW-1:0]   w_norm, w_man2;
    logic [EXP_W:0]    w_exp2;
    logic              w_sign2;
    assign w_sum     = r1_eff_sub ? ({1'b0, r1_ml} - {1'b0, r1_ms})
                                  : ({1'b0, r1_ml} + {1'b0, r1_ms});
    assign w_lzc     = f_lzc(w_sum[c_FW-1:0]);
    assign w_lzc_ext = c_CW'(w_lzc);
    assign w_em1     = c_CW'(r1_exp) - c_CW'(1);
    // Never normalise below exponent 1; what is left over is a subnormal.
    assign w_lshift  = (w_lzc_ext < w_em1) ? w_lzc_ext : w_em1;
    assign w_norm    = w_sum[c_FW-1:0] << w_lshift;
    assign w_sign2   = ((w_sum == '0) && r1_eff_sub) ? 1'b0 : r1_sign;

    always_comb begin
        if (w_sum[c_FW]) begin
            w_man2 = {w_sum[c_FW:2], w_sum[1] | w_sum[0]};
            w_exp2 = {1'b0, r1_exp} + (EXP_W+1)'(1);
        end else begin
            w_man2 = w_norm;
            w_exp2 = w_norm[c_FW-1] ? (EXP_W+1)'(c_CW'(r1_exp) - w_lshift) : '0;
        end
    end

    logic             r2_valid, r2_sign, r2_special, r2_invalid;
    logic [EXP_W:0]   r2_exp;
    logic [c_FW-1:0]  r2_man;
    logic [c_W-1:0]   r2_special_res;

    // ---------------- S3: round / pack ----------------
    logic             w_g, w_r, w_st, w_rnd_up, w_inexact3, w_ovf3;
    logic [MAN_W+1:0] w_rounded;
    logic [EXP_W:0]   w_exp3;
    logic [MAN_W-1:0] w_frac3;
    assign w_g       = r2_man[2];
    assign w_r       = r2_man[1];
    assign w_st      = r2_man[0];
    assign w_rnd_up  = w_g & (w_r | w_st | r2_man[3]);
    assign w_rounded = {1'b0, r2_man[c_FW-1:3]} + (MAN_W+2)'(w_rnd_up);
    assign w_inexact3 = w_g | w_r | w_st;

    always_comb begin
        w_exp3  = r2_exp;
        w_frac3 = w_rounded[MAN_W-1:0];
        if (w_rounded[MAN_W+1]) begin
            w_exp3  = r2_exp + (EXP_W+1)'(1);
            w_frac3 = w_rounded[MAN_W:1];
        end else if ((r2_exp == '0) && w_rounded[MAN_W]) begin
            // Largest subnormal rounded up into the smallest normal.
            w_exp3 = (EXP_W+1)'(1);
        end
    end
    assign w_ovf3 = w_exp3 >= {1'b0, c_EXP_ONES};

    logic [c_W-1:0] w_res3;
    logic           w_inv3, w_ovf_o, w_inx_o;
    always_comb begin
        w_res3  = {r2_sign, w_exp3[EXP_W-1:0], w_frac3};
        w_inv3  = 1'b0;
        w_ovf_o = 1'b0;
        w_inx_o = w_inexact3;
        if (r2_special) begin
            w_res3  = r2_special_res;
            w_inv3  = r2_invalid;
            w_inx_o = 1'b0;
        end else if (w_ovf3) begin
            w_res3  = {r2_sign, c_EXP_ONES, {MAN_W{1'b0}}};
            w_ovf_o = 1'b1;
            w_inx_o = 1'b1;
        end
    end

    logic [c_W-1:0] r3_res;
    logic           r3_inv, r3_ovf, r3_inx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r1_valid <= 1'b0; r1_sign <= 1'b0; r1_eff_sub <= 1'b0; r1_special <= 1'b0;
            r1_invalid <= 1'b0; r1_exp <= '0; r1_ml <= '0; r1_ms <= '0; r1_special_res <= '0;
            r2_valid <= 1'b0; r2_sign <= 1'b0; r2_special <= 1'b0; r2_invalid <= 1'b0;
            r2_exp <= '0; r2_man <= '0; r2_special_res <= '0;
            r3_valid <= 1'b0; r3_res <= '0; r3_inv <= 1'b0; r3_ovf <= 1'b0; r3_inx <= 1'b0;
        end else if (w_advance) begin
            r1_valid       <= in_valid;
            r1_sign        <= w_sl;
            r1_eff_sub     <= w_sa ^ w_sb;
            r1_special     <= w_special;
            r1_invalid     <= w_invalid;
            r1_exp         <= w_el_eff;
            r1_ml          <= {w_hl, w_fl, 3'b000};
            r1_ms          <= w_s_aligned;
            r1_special_res <= w_special_res;

            r2_valid       <= r1_valid;
            r2_sign        <= w_sign2;
            r2_special     <= r1_special;
            r2_invalid     <= r1_invalid;
            r2_exp         <= w_exp2;
            r2_man         <= w_man2;
            r2_special_res <= r1_special_res;

            r3_valid       <= r2_valid;
            r3_res         <= w_res3;
            r3_inv         <= w_inv3;
            r3_ovf         <= w_ovf_o;
            r3_inx         <= w_inx_o;
        end
    end

    assign out_valid     = r3_valid;
    assign res           = r3_res;
    assign flag_invalid  = r3_inv;
    assign flag_overflow = r3_ovf;
    assign flag_inexact  = r3_inx;

endmodule
`default_nettype wire

// File: tb/tb_fp_addsub_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_addsub_pipe
// Purpose  : Self-checking bench for fp_addsub_pipe (binary32 and binary16
//            instances). Expected results are queued at operand acceptance
//            and compared when the matching result is handed out.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fp_addsub_pipe;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic [31:0] res;
        logic [2:0]  flags;   // {invalid, overflow, inexact}
    } vec_t;

    typedef struct packed {
        logic [31:0] res;
        logic [2:0]  flags;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid, in_ready, sub, out_valid, out_ready;
    logic [31:0] a, b, res;
    logic        flag_invalid, flag_overflow, flag_inexact;

    logic        in_valid16, in_ready16, sub16, out_valid16, out_ready16;
    logic [15:0] a16, b16, res16;
    logic        inv16, ovf16, inx16;

    fp_addsub_pipe dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
        .res(res), .flag_invalid(flag_invalid), .flag_overflow(flag_overflow),
        .flag_inexact(flag_inexact)
    );

    fp_addsub_pipe #(.EXP_W(5), .MAN_W(10)) dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
        .a(a16), .b(b16), .sub(sub16), .out_valid(out_valid16), .out_ready(out_ready16),
        .res(res16), .flag_invalid(inv16), .flag_overflow(ovf16), .flag_inexact(inx16)
    );

    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_accepted = 0;
    exp_t sb_q[$];
    exp_t cur_exp;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    endtask

    // Scoreboard: handshakes are observed mid-cycle, ahead of the edge that completes them.
    always @(negedge clk) begin
        if (!rst) begin
            if (in_valid && in_ready) begin
                sb_q.push_back(cur_exp);
                n_accepted++;
            end
            if (out_valid && out_ready) begin
                check("result_expected", 64'(sb_q.size() != 0), 64'(1));
                if (sb_q.size() != 0) begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("res", 64'(res), 64'(e.res));
                    check("flags", 64'({flag_invalid, flag_overflow, flag_inexact}), 64'(e.flags));
                end
            end
        end
    end

    function automatic vec_t mk(input logic [31:0] ia, input logic [31:0] ib, input logic isub,
                                input logic [31:0] ires, input logic [2:0] iflags);
        vec_t v;
        v.a = ia; v.b = ib; v.sub = isub; v.res = ires; v.flags = iflags;
        return v;
    endfunction

    // Present one operand pair and hold it until accepted (bounded).
    task automatic send(input vec_t v);
        int   tries;
        logic hs;
        tries = 0;
        hs = 1'b0;
        in_valid = 1'b1; a = v.a; b = v.b; sub = v.sub;
        cur_exp.res = v.res; cur_exp.flags = v.flags;
        while (!hs && tries < 50) begin
            @(negedge clk);
            hs = in_valid && in_ready;
            tries++;
            @(posedge clk); #1;
        end
        if (!hs) check("accept_timeout", 64'(0), 64'(1));
    endtask

    task automatic drain();
        int tries;
        tries = 0;
        while (sb_q.size() != 0 && tries < 50) begin
            @(posedge clk); #1;
            tries++;
        end
        check("drain_empty", 64'(sb_q.size()), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    vec_t vecs[23];
    vec_t bp[4];

    initial begin
        int   lat, idx, start, cnt, tries;
        logic [31:0] held;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; sub = 1'b0;
        cur_exp = '0;
        in_valid16 = 1'b0; out_ready16 = 1'b1; a16 = '0; b16 = '0; sub16 = 1'b0;

        vecs[0]  = mk(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 3'b000);
        vecs[1]  = mk(32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 3'b000);
        vecs[2]  = mk(32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 3'b000);
        vecs[3]  = mk(32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 3'b001);
        vecs[4]  = mk(32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 3'b001);
        vecs[5]  = mk(32'h00000001, 32'h00000001, 1'b0, 32'h00000002, 3'b000);
        vecs[6]  = mk(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 3'b011);
        vecs[7]  = mk(32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 3'b100);
        vecs[8]  = mk(32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 3'b100);
        vecs[9]  = mk(32'h7FC00000, 32'h3F800000, 1'b0, 32'h7FC00000, 3'b000);
        vecs[10] = mk(32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 3'b000);
        vecs[11] = mk(32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 3'b100);
        vecs[12] = mk(32'h00000000, 32'h40400000, 1'b0, 32'h40400000, 3'b000);
        vecs[13] = mk(32'h40000000, 32'h3F800000, 1'b1, 32'h3F800000, 3'b000);
        vecs[14] = mk(32'h3F800000, 32'hBF800000, 1'b0, 32'h00000000, 3'b000);
        vecs[15] = mk(32'h00800000, 32'h00000001, 1'b1, 32'h007FFFFF, 3'b000);
        vecs[16] = mk(32'h3FC00000, 32'h40000000, 1'b0, 32'h40600000, 3'b000);
        vecs[17] = mk(32'h3F800000, 32'h33800000, 1'b1, 32'h3F7FFFFF, 3'b000);
        vecs[18] = mk(32'hC0000000, 32'h3F800000, 1'b0, 32'hBF800000, 3'b000);
        vecs[19] = mk(32'h7FC00000, 32'h7F800001, 1'b0, 32'h7FC00000, 3'b100);
        vecs[20] = mk(32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 3'b000);
        vecs[21] = mk(32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, 3'b000);
        vecs[22] = mk(32'h007FFFFF, 32'h00000001, 1'b0, 32'h00800000, 3'b000);

        bp[0] = mk(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 3'b000);
        bp[1] = mk(32'h40000000, 32'h3F800000, 1'b0, 32'h40400000, 3'b000);
        bp[2] = mk(32'h40400000, 32'h3F800000, 1'b0, 32'h40800000, 3'b000);
        bp[3] = mk(32'h40800000, 32'h40800000, 1'b0, 32'h41000000, 3'b000);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_res", 64'(res), 64'(0));
        check("rst_flags", 64'({flag_invalid, flag_overflow, flag_inexact}), 64'(0));
        check("rst_in_ready", 64'(in_ready), 64'(0));
        rst = 1'b0;
        @(negedge clk);
        check("in_ready_after_rst", 64'(in_ready), 64'(1));
        @(posedge clk); #1;

        // Latency: 1.0 + 1.0, counted in edges from the accepting edge
        in_valid = 1'b1; a = vecs[0].a; b = vecs[0].b; sub = 1'b0;
        cur_exp.res = vecs[0].res; cur_exp.flags = vecs[0].flags;
        @(negedge clk);
        check("lat_accept", 64'(in_ready), 64'(1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (lat < 10) begin
            @(negedge clk);
            if (out_valid) break;
            @(posedge clk); #1;
            lat++;
        end
        check("latency", 64'(lat), 64'(3));
        @(posedge clk); #1;
        drain();

        // Table, streamed back-to-back
        foreach (vecs[i]) send(vecs[i]);
        in_valid = 1'b0;
        drain();

        // Backpressure: out_ready low for 5 cycles with 4 pairs offered
        out_ready = 1'b0;
        idx = 0;
        start = n_accepted;
        for (int c = 0; c < 5; c++) begin
            in_valid = (idx < 4);
            a = bp[idx < 4 ? idx : 3].a; b = bp[idx < 4 ? idx : 3].b; sub = 1'b0;
            cur_exp.res = bp[idx < 4 ? idx : 3].res; cur_exp.flags = bp[idx < 4 ? idx : 3].flags;
            @(negedge clk);
            if (in_valid && in_ready) idx++;
            @(posedge clk); #1;
        end
        check("bp_accepted", 64'(n_accepted - start), 64'(3));
        check("bp_in_ready", 64'(in_ready), 64'(0));
        check("bp_out_valid", 64'(out_valid), 64'(1));
        held = res;
        repeat (2) @(posedge clk);
        #1;
        check("bp_res_stable", 64'(res), 64'(held));
        check("bp_res_first", 64'(res), 64'(bp[0].res));
        out_ready = 1'b1;
        tries = 0;
        while (idx < 4 && tries < 20) begin
            in_valid = 1'b1;
            a = bp[idx].a; b = bp[idx].b; sub = 1'b0;
            cur_exp.res = bp[idx].res; cur_exp.flags = bp[idx].flags;
            @(negedge clk);
            if (in_valid && in_ready) idx++;
            @(posedge clk); #1;
            tries++;
        end
        in_valid = 1'b0;
        drain();
        check("bp_total", 64'(n_accepted - start), 64'(4));

        // Reset with two results in flight, one already presented
        out_ready = 1'b0;
        send(vecs[3]);
        send(vecs[4]);
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("mid_out_valid", 64'(out_valid), 64'(1));
        #2 rst = 1'b1;
        #1;
        check("async_out_valid", 64'(out_valid), 64'(0));
        check("async_res", 64'(res), 64'(0));
        check("async_in_ready", 64'(in_ready), 64'(0));
        sb_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) cnt++;
        end
        check("no_stale_output", 64'(cnt), 64'(0));
        @(posedge clk); #1;
        send(vecs[16]);
        in_valid = 1'b0;
        drain();

        // Half-precision instance: 1.0 + 1.0
        in_valid16 = 1'b1; a16 = 16'h3C00; b16 = 16'h3C00; sub16 = 1'b0;
        tries = 0;
        while (tries < 20) begin
            @(negedge clk);
            if (in_ready16) break;
            tries++;
        end
        @(posedge clk); #1;
        in_valid16 = 1'b0;
        tries = 0;
        while (tries < 20) begin
            @(negedge clk);
            if (out_valid16) break;
            tries++;
        end
        check("h16_out_valid", 64'(out_valid16), 64'(1));
        check("h16_res", 64'(res16), 64'(16'h4000));
        check("h16_flags", 64'({inv16, ovf16, inx16}), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
